multi_prescaler: RTL
====================

// Module: multi_prescaler
// PURPOSE
//  N-channel programmable clock-enable generator; the next generation of the single fixed-RATIO prescaler.
//  Each channel divides the system clock by a runtime-loadable ratio.
//  Each channel outputs a one-cycle tick (clock enable) and a 50%-duty level (slow square wave).
//  Sits between the board clock/reset pins and the CPU core, LED refresh and switch debounce logic.
//  Ratio updates are glitch-free: shadowed and applied only at a period boundary or on sync.
// PARAMETERS
//  CHANNELS       4           number of independent divider channels (>=1)
//  WIDTH          32          width of ratio and counter registers
//  DEFAULT_RATIO  50_000_000  ratio loaded into every channel at reset (1..2**WIDTH-1)
// PORTS
//  clock        in   1              system clock, all logic on rising edge
//  reset        in   1              asynchronous, active-high reset
//  enable       in   1              global run; 0 freezes all counters and levels
//  sync         in   1              realign: clear all counters and levels, apply pending ratios
//  ratio_we     in   CHANNELS       per-channel write strobe for ratio_wdata
//  ratio_wdata  in   WIDTH          new ratio value (0 is treated as 1)
//  tick         out  CHANNELS       one-cycle pulse once per ratio cycles
//  level        out  CHANNELS       toggles at each tick; period = 2*ratio cycles
//  pending      out  CHANNELS       shadow ratio written but not yet active
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - ratio = shadow = DEFAULT_RATIO, counter = 0.
//   - tick = 0, level = 0, pending = 0.
//  Per channel i, on each rising edge, in priority order:
//   1. sync=1:
//      - counter <= 0, tick <= 0, level <= 0.
//      - ratio <= shadow, or ratio_wdata if ratio_we[i] is high this cycle; pending <= 0.
//   2. enable=0:
//      - counter and level hold, tick <= 0.
//      - A ratio write updates shadow and sets pending.
//   3. enable=1, counter == eff_ratio-1 (wrap):
//      - counter <= 0, tick <= 1, level <= ~level.
//      - ratio <= shadow, pending <= 0.
//      - A ratio_we in the same cycle wins: it goes directly to ratio, pending <= 0.
//   4. enable=1, otherwise:
//      - counter <= counter+1, tick <= 0.
//      - A ratio write updates shadow and sets pending.
//  Ratio rules:
//   - eff_ratio = (ratio==0) ? 1 : ratio.
//   - Ratio 1 gives tick=1 every enabled cycle and level toggling every cycle.
//  Latency:
//   - tick/level are registered; first tick is high in the cycle after the eff_ratio-th enabled edge following reset release or sync.
//   - A new ratio affects period length starting with the period after the next wrap.
//  Counter: never exceeds eff_ratio-1; no wrap-around past 2**WIDTH-1.
//  Back-to-back writes before a wrap: the last write wins; pending stays 1.
//  Channels are fully independent except for the shared enable and sync.
//  Reset mid-period: all state returns to reset values immediately (async); no tick is emitted.
// TESTING
//  T1 CHANNELS=2, DEFAULT_RATIO=2, enable=1 after reset:
//     -> tick[0] high every 2nd cycle; level[0] period 4 cycles; both channels identical.
//  T2 Write ratio 5 to ch1 mid-period:
//     -> pending[1]=1 until the next ch1 wrap; then ticks every 5 cycles; ch0 unaffected.
//  T3 Ratio 0 and ratio 1 written with sync pulse:
//     -> tick held high every enabled cycle; level toggles each cycle.
//  T4 enable=0 for 7 cycles mid-period with ratio 4:
//     -> no ticks; counter/level frozen; the next tick arrives exactly 4-(count at freeze) enabled cycles after resume.
//  T5 sync asserted with counters at various values:
//     -> next cycle all counters=0, levels=0, tick=0; thereafter channels with equal ratios tick in lockstep.
//  T6 reset asserted asynchronously mid-period, between clock edges:
//     -> outputs clear before the next edge; ratio returns to DEFAULT_RATIO; pending=0.

Source files
------------

// File: rtl/multi_prescaler.sv
// multi_prescaler: N-channel programmable clock-enable generator with tick and 50% level outputs.
// Ratio writes are shadowed and take effect only at a period wrap or on sync, so periods never glitch.
module multi_prescaler #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] DEFAULT_RATIO = WIDTH'(50_000_000)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_sync,
  input  logic [CHANNELS-1:0] i_ratio_we,
  input  logic [WIDTH-1:0]    i_ratio_wdata,
  output logic [CHANNELS-1:0] o_tick,
  output logic [CHANNELS-1:0] o_level,
  output logic [CHANNELS-1:0] o_pending
);
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] r_ratio, r_shadow, r_cnt;
    logic             r_tick, r_level, r_pending;
    logic [WIDTH-1:0] w_eff;
    logic             w_wrap, w_we;
    // a stored ratio of 0 behaves exactly like 1
    assign w_eff  = (r_ratio == '0) ? WIDTH'(1) : r_ratio;
    assign w_wrap = r_cnt == w_eff - WIDTH'(1);
    assign w_we   = i_ratio_we[g];
    always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
        r_ratio   <= DEFAULT_RATIO;
        r_shadow  <= DEFAULT_RATIO;
        r_cnt     <= '0;
        r_tick    <= 1'b0;
        r_level   <= 1'b0;
        r_pending <= 1'b0;
      end else if (i_sync || (i_enable && w_wrap)) begin
        // a write landing on a boundary bypasses the shadow and is applied at once
        r_cnt     <= '0;
        r_tick    <= !i_sync;
        r_level   <= i_sync ? 1'b0 : ~r_level;
        r_ratio   <= w_we ? i_ratio_wdata : r_shadow;
        r_shadow  <= w_we ? i_ratio_wdata : r_shadow;
        r_pending <= 1'b0;
      end else begin
        r_cnt     <= i_enable ? r_cnt + WIDTH'(1) : r_cnt;
        r_tick    <= 1'b0;
        r_shadow  <= w_we ? i_ratio_wdata : r_shadow;
        r_pending <= w_we | r_pending;
      end
    end
    assign o_tick[g]    = r_tick;
    assign o_level[g]   = r_level;
    assign o_pending[g] = r_pending;
  end
endmodule
